// File: rtl/aes_pkg.sv
// Shared AES loader definitions: block geometry and the loader FSM encoding.
package aes_pkg;

    localparam int AES_BLOCK_BYTES = 16;
    localparam int AES_BLOCK_W     = 128;
    localparam int CNT_W           = $clog2(AES_BLOCK_BYTES);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(AES_BLOCK_BYTES - 1);

    typedef enum logic {
        LOAD = 1'b0,
        HOLD = 1'b1
    } loader_state_t;

endpackage

// File: rtl/aes_byte_shreg.sv
// Byte-wide shift register assembling a 128-bit field, first byte ending up in the top byte.
module aes_byte_shreg
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   en,
    input  logic [7:0]             d,
    output logic [AES_BLOCK_W-1:0] q
);

    // clr together with en restarts the field with d as its first byte.
    always_ff @(posedge clk) begin
        if (clr && en) begin
            q <= {{(AES_BLOCK_W - 8){1'b0}}, d};
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= {q[AES_BLOCK_W-9:0], d};
        end
    end

endmodule

// File: rtl/aes_in_loader.sv
// Collects key and plaintext bytes into 128-bit fields and presents a key/data pair to the cipher core.
module aes_in_loader
    import aes_pkg::*;
#(
    parameter bit KEEP_KEY = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_byte,
    input  logic                   in_sel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] data_out,
    output logic [AES_BLOCK_W-1:0] key_out,
    output logic                   err,
    output logic                   fsm_state
);

    // Handshake: a byte moves when in_valid && in_ready at a rising edge; the pair
    // moves when out_valid && out_ready at a rising edge. Ready/valid outputs are registers.

    loader_state_t          state_q, state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic                   field_sel_q;
    logic                   key_loaded_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic                   err_q;
    logic [AES_BLOCK_W-1:0] asm_q;
    logic [AES_BLOCK_W-1:0] full_block;
    logic                   unused_asm_msb;

    logic accept;
    logic mismatch;
    logic field_done;
    logic load_key;
    logic load_data;
    logic drop;
    logic handoff;

    // The oldest byte falls off the top as the 16th byte enters, so it is never read.
    assign full_block     = {asm_q[AES_BLOCK_W-9:0], in_byte};
    assign unused_asm_msb = ^asm_q[AES_BLOCK_W-1:AES_BLOCK_W-8];

    aes_byte_shreg u_shreg (
        .clk (clk),
        .clr (rst || mismatch),
        .en  (accept && !rst),
        .d   (in_byte),
        .q   (asm_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        mismatch   = 1'b0;
        field_done = 1'b0;
        load_key   = 1'b0;
        load_data  = 1'b0;
        drop       = 1'b0;
        handoff    = 1'b0;
        case (state_q)
            LOAD: begin
                accept = in_valid && in_ready_q;
                if (accept) begin
                    mismatch   = (cnt_q != '0) && (in_sel != field_sel_q);
                    field_done = !mismatch && (cnt_q == LAST_IDX);
                    if (field_done) begin
                        if (field_sel_q) begin
                            load_key = 1'b1;
                        end else if (key_loaded_q) begin
                            load_data = 1'b1;
                            state_d   = HOLD;
                        end else begin
                            drop = 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    handoff = 1'b1;
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            field_sel_q  <= 1'b0;
            key_loaded_q <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            data_out     <= '0;
            key_out      <= '0;
        end else begin
            in_ready_q  <= (state_d == LOAD);
            out_valid_q <= (state_d == HOLD);
            err_q       <= mismatch || drop;
            if (accept) begin
                // A type change restarts the field with this byte as byte 0.
                if (mismatch) begin
                    cnt_q       <= CNT_W'(1);
                    field_sel_q <= in_sel;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == '0) begin
                        field_sel_q <= in_sel;
                    end
                end
            end
            if (load_key) begin
                key_out      <= full_block;
                key_loaded_q <= 1'b1;
            end
            if (load_data) begin
                data_out <= full_block;
            end
            if (handoff && !KEEP_KEY) begin
                key_loaded_q <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign fsm_state = state_q;

endmodule

// File: doc/aes_in_loader.md
AES_IN_LOADER -- requirements
Module: aes_in_loader

Interface
REQ-001 Parameter KEEP_KEY, default 1: 1 = loaded key persists across blocks; 0 = key consumed by each handoff.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 in_valid  in  1  upstream byte valid.
REQ-006 in_ready  out  1  loader accepts a byte this cycle.
REQ-007 in_byte  in  8  byte payload; first byte of a field maps to bits [0:7], 16th to [120:127].
REQ-008 in_sel  in  1  0 = byte belongs to plaintext block, 1 = byte belongs to key.
REQ-009 out_valid  out  1  data_out/key_out hold a complete pair for the cipher core.
REQ-010 out_ready  in  1  cipher side consumes the pair.
REQ-011 data_out  out  128  plaintext block, big-endian [0:127], feeds cipher core data input.
REQ-012 key_out  out  128  cipher key, big-endian [0:127], feeds cipher core key input.
REQ-013 err  out  1  one-cycle pulse on protocol error.

Function
REQ-014 A byte transfers when in_valid && in_ready at a rising clk edge; one byte per cycle maximum.
REQ-015 States: LOAD (collecting bytes, in_ready=1) and HOLD (pair presented, in_ready=0, out_valid=1).
REQ-016 In LOAD a 4-bit byte counter indexes the current field; the in_sel value of byte 0 is latched as the field type.
REQ-017 Each accepted byte shifts into a 128-bit assembly register; counter increments, wrapping 15 -> 0 on field completion.
REQ-018 Key field completion: assembly copied to key_out, key_loaded set, state stays LOAD.
REQ-019 Data field completion with key_loaded=1: assembly copied to data_out, LOAD -> HOLD; out_valid high the following cycle.
REQ-020 Data field completion with key_loaded=0: block discarded, err pulses next cycle, state stays LOAD.
REQ-021 in_sel differing from the latched field type at counter 1..15: partial field discarded, the current byte becomes byte 0 of a new field of the new type, err pulses next cycle.
REQ-022 HOLD: out_valid && out_ready -> LOAD with in_ready=1 on the next cycle; data_out/key_out stable throughout HOLD.
REQ-023 On handoff with KEEP_KEY=0, key_loaded clears; with KEEP_KEY=1 it stays set and key_out unchanged.
REQ-024 A key field completing while key_loaded=1 overwrites key_out; a data field already in HOLD is unaffected (no input accepted in HOLD).
REQ-025 Latency: 16th data byte accepted at edge N -> out_valid=1 after edge N; minimum 17 cycles between successive out_valid rises (16 bytes + handoff).
REQ-026 out_valid, in_ready, err driven directly from registers; no combinational path from in_valid/out_ready to any output.

Reset
REQ-027 rst=1 at an edge: state=LOAD, counter=0, key_loaded=0, out_valid=0, err=0, data_out=0, key_out=0, assembly=0; in_ready=1 on the first cycle after rst deasserts.
REQ-028 rst mid-field or in HOLD discards all partial and held content; no err pulse is generated by reset.

Structure
REQ-029 Shared package aes_pkg: AES_BLOCK_BYTES=16, AES_BLOCK_W=128, loader state enum {LOAD, HOLD}.
REQ-030 One natural sub-module: aes_byte_shreg (8-bit in, 128-bit parallel out, shift-enable, sync clear); remaining control inline.

Verification
REQ-031 Key 000102030405060708090a0b0c0d0e0f then data 00112233445566778899aabbccddeeff, out_ready=1 -> out_valid one cycle after 32nd byte, key_out/data_out equal those values, core output 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-032 Data 16 bytes with no key loaded -> err pulses once, out_valid stays 0, in_ready stays 1.
REQ-033 Key bytes 0..5 then in_sel=0 byte -> err pulse; following 16 data bytes (after valid key) handed off with correct data_out.
REQ-034 HOLD with out_ready=0 for 10 cycles -> in_ready=0, outputs stable; out_ready=1 -> in_ready=1 next cycle.
REQ-035 KEEP_KEY=1: two data blocks after one key -> two handoffs with same key_out; KEEP_KEY=0: second block -> err, no handoff.
REQ-036 rst asserted at byte 9 of a data field and in HOLD -> all outputs zero, out_valid=0, next full key+data sequence handed off correctly.
